uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Receive side of the UART link: oversampled serial receiver that recovers frames sent by our TX (start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit; idle line high).
- Synchronises RX_IN, detects the start edge, majority-votes each bit at mid-period, checks parity and stop bit, and delivers a parallel word with a single-cycle valid pulse.
- Sits between the pad/line and the system-side RX consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 8, CLK cycles per bit period. Must be even and at least 4. H = OVERSAMPLE/2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- RX_IN  in  1  serial line, asynchronous to CLK; idles high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  last correctly received word.
- Data_Valid  out  1  one-cycle pulse when P_DATA is updated.
- Parity_Error  out  1  one-cycle pulse when the frame's parity check fails.
- Stop_Error  out  1  one-cycle pulse when the sampled stop bit is 0.
- busy  out  1  high while a frame is being received.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Outputs: P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0, busy=0.
  - Internals: state=IDLE, synchroniser flops=1, counters=0.
  - Reset mid-frame abandons the frame with no pulses.
- Synchroniser: RX_IN passes through 2 flops; rx_s is the second flop. All decisions use rx_s.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within a bit period, then wraps to 0.
  - bit_cnt runs 0..DATA_WIDTH-1 and counts data bits.
- Bit decision: majority of rx_s at edge_cnt = H-1, H and H+1, registered at edge_cnt = H+1.
- States (one-hot):
  - IDLE: busy=0. rx_s=0 moves to START with edge_cnt=0 on the detection cycle. PAR_EN and PAR_TYP are latched on this cycle and held for the whole frame.
  - START: busy=1. A decision of 1 is a glitch: return to IDLE at edge_cnt=H+1 with no pulses. A decision of 0 goes to DATA at the end of the bit period.
  - DATA: shift each decided bit into bit position bit_cnt (LSB first). After the bit with bit_cnt=DATA_WIDTH-1 ends, go to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: at the decision, compare the bit with the computed parity. Even: XOR of the data bits. Odd: inverted XOR. Record a mismatch. Go to STOP at the end of the period.
  - STOP: at the decision (edge_cnt=H+1), evaluate the frame and return to IDLE on the next cycle. busy falls in that same cycle. IDLE is entered mid-stop-bit so that a back-to-back start edge is caught.
- Frame result, asserted in the cycle after the stop decision:
  - Stop bit 0: Stop_Error=1.
  - Parity mismatch: Parity_Error=1. Both errors may pulse together.
  - Data_Valid=1 and P_DATA loaded only if neither error occurs. Otherwise P_DATA holds its old value.
  - All three flags are high for exactly one cycle.
- Latency: N = 1 + DATA_WIDTH + PAR_EN + 1. Data_Valid occurs (N-1)*OVERSAMPLE + H + 2 cycles after the IDLE detection cycle. Defaults: 78 cycles without parity, 86 with parity.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- A line stuck low after a failed stop bit re-triggers START immediately on return to IDLE. This is intended.

Test Plan:
- Reset, then frame 0xA5 with PAR_EN=0 and bit period = 8 CLK -> P_DATA=0xA5; Data_Valid high for 1 cycle, 78 cycles after detection; no error pulses; busy falls in the same cycle.
- PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0 -> P_DATA=0x3C and Data_Valid at 86 cycles. Repeat with PAR_TYP=1 and parity bit 1 -> valid.
- Data 0x3C, even parity, parity bit 1 -> Parity_Error pulses once; no Data_Valid; P_DATA keeps its previous value.
- Frame 0x81 with stop bit driven 0 -> Stop_Error pulses once; no Data_Valid. Line then returns high with no new frame -> stays IDLE.
- RX_IN low for 2 cycles then high -> START aborts at edge_cnt=H+1, busy returns to 0, no pulses. Single-cycle noise on one data-bit mid-sample -> majority vote still yields the correct word.
- Back-to-back frames 0x55 then 0xAA with no idle gap -> two Data_Valid pulses, 80 cycles apart, with the correct data. RST asserted during bit 4 of a frame -> all outputs 0 next cycle; the following frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Bundle of the line-side inputs and the word-side outputs of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Parity_Error;
  logic                  Stop_Error;
  logic                  busy;

  // Receiver side: samples the line and config, drives the result
  modport master (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
  );

  // Line driver / word consumer side
  modport slave (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 2-flop synchroniser, start-edge detect,
// 3-sample majority vote at mid-bit, optional parity, single stop bit.
// OVERSAMPLE must be even and >= 4.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low; config latched on detection
// START  | start bit; a voted 1 is treated as a glitch and aborts
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit, mismatch recorded
// STOP   | stop bit; frame result issued after the mid-bit vote
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_rx_if.master bus
);
  localparam int H  = OVERSAMPLE / 2;
  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_S0   = EW'(H - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(H);
  localparam logic [EW-1:0] EDGE_DEC  = EW'(H + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] START  = 5'b00010;
  localparam logic [4:0] DATA   = 5'b00100;
  localparam logic [4:0] PARITY = 5'b01000;
  localparam logic [4:0] STOP   = 5'b10000;

  logic                  sync1_q, sync1_d;
  logic                  rx_s_q, rx_s_d;
  logic [4:0]            state_q, state_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  samp0_q, samp0_d;
  logic                  samp1_q, samp1_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  logic vote;
  logic decide;
  logic period_end;

  // Majority of the two stored mid-bit samples and the current one
  assign vote       = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
  assign decide     = (edge_cnt_q == EDGE_DEC);
  assign period_end = (edge_cnt_q == EDGE_LAST);

  // Next-state logic: synchroniser, sampling, bit/edge counting and frame FSM
  always_comb begin
    sync1_d    = bus.RX_IN;
    rx_s_d     = sync1_q;
    state_d    = state_q;
    edge_cnt_d = period_end ? '0 : edge_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_err_d  = par_err_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;

    if (edge_cnt_q == EDGE_S0) samp0_d = rx_s_q;
    if (edge_cnt_q == EDGE_S1) samp1_d = rx_s_q;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s_q) begin
          // The detection cycle is slot 0 of the start bit
          state_d    = START;
          edge_cnt_d = EW'(1);
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_err_d  = 1'b0;
        end
      end
      START: begin
        if (decide && vote) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (period_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) data_d[bit_cnt_q] = vote;
        if (period_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (decide) par_err_d = (vote != ((^data_q) ^ par_typ_q));
        if (period_end) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed
        if (decide) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          serr_d     = ~vote;
          perr_d     = par_err_q;
          if (vote && !par_err_q) begin
            dv_d     = 1'b1;
            p_data_d = data_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp0_q    <= 1'b0;
      samp1_q    <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_err_q  <= par_err_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign bus.P_DATA       = p_data_q;
  assign bus.Data_Valid   = dv_q;
  assign bus.Parity_Error = perr_q;
  assign bus.Stop_Error   = serr_q;
  assign bus.busy         = (state_q != IDLE);
endmodule
